// File: rtl/de1_soc_top.sv
// DE1-SoC VGA image: 640x480@60 Hz timing and four selectable test patterns from clock_50.
// The pixel clock is clock_50/2; all pixel state advances on the edge where vga_clk rises.
module de1_soc_top #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clock_50,
    input  logic [3:0] key,
    output logic       vga_clk,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BW      = H_ACTIVE / 8;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] H_EDGE = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_EDGE = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] BAR1   = 10'(1 * BW);
    localparam logic [9:0] BAR2   = 10'(2 * BW);
    localparam logic [9:0] BAR3   = 10'(3 * BW);
    localparam logic [9:0] BAR4   = 10'(4 * BW);
    localparam logic [9:0] BAR5   = 10'(5 * BW);
    localparam logic [9:0] BAR6   = 10'(6 * BW);
    localparam logic [9:0] BAR7   = 10'(7 * BW);

    logic        clk_q;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_n_q, blank_n_d;
    logic [23:0] rgb_q, rgb_d;
    logic [23:0] bars_s;
    logic        tick_s;
    logic        unused_key_s;

    assign tick_s       = ~clk_q;
    assign unused_key_s = key[3];

    // Raster counters: h wraps at end of line and carries into v.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 10'd0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = 10'd0;
            end else begin
                v_cnt_d = v_cnt_q + 10'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q + 10'd1;
        end
    end

    // The frame-start pixel already uses the freshly loaded mode, so the whole frame is one pattern.
    always_comb begin
        if ((h_cnt_q == 10'd0) && (v_cnt_q == 10'd0)) begin
            mode_d = key[2:1];
        end else begin
            mode_d = mode_q;
        end
    end

    // Sync and blanking decode of the current raster position.
    always_comb begin
        blank_n_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_d      = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vs_d      = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    end

    // Colour-bar lookup by comparator chain.
    always_comb begin
        if (h_cnt_q < BAR1) begin
            bars_s = 24'hFFFFFF;
        end else if (h_cnt_q < BAR2) begin
            bars_s = 24'hFFFF00;
        end else if (h_cnt_q < BAR3) begin
            bars_s = 24'h00FFFF;
        end else if (h_cnt_q < BAR4) begin
            bars_s = 24'h00FF00;
        end else if (h_cnt_q < BAR5) begin
            bars_s = 24'hFF00FF;
        end else if (h_cnt_q < BAR6) begin
            bars_s = 24'hFF0000;
        end else if (h_cnt_q < BAR7) begin
            bars_s = 24'h0000FF;
        end else begin
            bars_s = 24'h000000;
        end
    end

    // Pattern select; forced to black outside the visible region.
    always_comb begin
        case (mode_d)
            2'b00: rgb_d = bars_s;
            2'b01: begin
                if ((h_cnt_q[4:0] == 5'd0) || (v_cnt_q[4:0] == 5'd0) ||
                    (h_cnt_q == H_EDGE) || (v_cnt_q == V_EDGE)) begin
                    rgb_d = 24'hFFFFFF;
                end else begin
                    rgb_d = 24'h000000;
                end
            end
            2'b10: rgb_d = {h_cnt_q[9:2], h_cnt_q[9:2], h_cnt_q[9:2]};
            2'b11: rgb_d = (h_cnt_q[5] ^ v_cnt_q[5]) ? 24'hFFFFFF : 24'h000000;
            default: rgb_d = 24'h000000;
        endcase
        if (!blank_n_d) begin
            rgb_d = 24'h000000;
        end else begin
            rgb_d = rgb_d;
        end
    end

    // State and output registers; pixel state moves only on pixel ticks.
    always_ff @(posedge clock_50) begin
        if (key[0]) begin
            clk_q     <= 1'b0;
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 10'd0;
            mode_q    <= 2'b00;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            rgb_q     <= 24'h000000;
        end else begin
            clk_q <= ~clk_q;
            if (tick_s) begin
                h_cnt_q   <= h_cnt_d;
                v_cnt_q   <= v_cnt_d;
                mode_q    <= mode_d;
                hs_q      <= hs_d;
                vs_q      <= vs_d;
                blank_n_q <= blank_n_d;
                rgb_q     <= rgb_d;
            end else begin
                rgb_q <= rgb_q;
            end
        end
    end

    assign vga_clk     = clk_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_de1_soc_top.sv
// Bench for de1_soc_top: full-width lines with a shortened frame so several frames fit the run.
// A pixel-index model predicts every output each clock_50 cycle; literal pixels pin the model.
module tb_de1_soc_top;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 6, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME_CYC = 2 * HT * VT;

    logic       clock_50 = 1'b0;
    logic [3:0] key = 4'b0001;
    logic       vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
    logic [7:0] vga_r, vga_g, vga_b;

    int checks = 0;
    int errors = 0;

    always #10 clock_50 = ~clock_50;

    de1_soc_top #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clock_50   (clock_50),
        .key        (key),
        .vga_clk    (vga_clk),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_blank_n(vga_blank_n),
        .vga_sync_n (vga_sync_n),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b)
    );

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [23:0] pattern(input int h, input int v, input logic [1:0] m);
        logic [7:0] g;
        case (m)
            2'b00: begin
                case (h / (HA / 8))
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2'b01: return ((h % 32 == 0) || (v % 32 == 0) || (h == HA - 1) || (v == VA - 1))
                          ? 24'hFFFFFF : 24'h000000;
            2'b10: begin
                g = 8'(h / 4);
                return {g, g, g};
            end
            default: return (((h / 32) + (v / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    // Behavioural model: pixel index since reset release determines raster position.
    int         pix = 0;
    bit         ph = 1'b0;
    logic [1:0] fmode = 2'b00;
    int         exp_h = -1, exp_v = -1;
    logic       exp_clk, exp_hs, exp_vs, exp_bn;
    logic [23:0] exp_rgb;
    bit         model_ok = 1'b0;

    always @(posedge clock_50) begin
        if (key[0]) begin
            pix = 0; ph = 1'b0; fmode = 2'b00; exp_h = -1; exp_v = -1;
            exp_clk = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1; exp_bn = 1'b0; exp_rgb = 24'h0;
        end else begin
            if (!ph) begin
                exp_h = pix % HT;
                exp_v = (pix / HT) % VT;
                if (exp_h == 0 && exp_v == 0) fmode = key[2:1];
                exp_bn  = (exp_h < HA) && (exp_v < VA);
                exp_hs  = !((exp_h >= HA + HF) && (exp_h < HA + HF + HS));
                exp_vs  = !((exp_v >= VA + VF) && (exp_v < VA + VF + VS));
                exp_rgb = exp_bn ? pattern(exp_h, exp_v, fmode) : 24'h0;
                pix++;
            end
            ph = !ph;
            exp_clk = ph;
        end
        model_ok = 1'b1;
    end

    // Compare every cycle, away from the active edge, plus literal pixels.
    always @(negedge clock_50) begin
        if (model_ok) begin
            check("vga_clk", {23'd0, vga_clk}, {23'd0, exp_clk});
            check("vga_hs", {23'd0, vga_hs}, {23'd0, exp_hs});
            check("vga_vs", {23'd0, vga_vs}, {23'd0, exp_vs});
            check("vga_blank_n", {23'd0, vga_blank_n}, {23'd0, exp_bn});
            check("vga_sync_n", {23'd0, vga_sync_n}, 24'd0);
            check("rgb", {vga_r, vga_g, vga_b}, exp_rgb);
            if (exp_clk && exp_v == 1 && fmode == 2'b00) begin
                if (exp_h == 79)  check("bars_px79", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
                if (exp_h == 80)  check("bars_px80", {vga_r, vga_g, vga_b}, 24'hFFFF00);
                if (exp_h == 400) check("bars_px400", {vga_r, vga_g, vga_b}, 24'hFF0000);
                if (exp_h == 639) check("bars_px639", {vga_r, vga_g, vga_b}, 24'h000000);
                if (exp_h == 640) begin
                    check("bars_px640_rgb", {vga_r, vga_g, vga_b}, 24'h000000);
                    check("bars_px640_blank", {23'd0, vga_blank_n}, 24'd0);
                end
                if (exp_h == 655) check("hs_px655", {23'd0, vga_hs}, 24'd1);
                if (exp_h == 656) check("hs_px656", {23'd0, vga_hs}, 24'd0);
                if (exp_h == 751) check("hs_px751", {23'd0, vga_hs}, 24'd0);
                if (exp_h == 752) check("hs_px752", {23'd0, vga_hs}, 24'd1);
            end
            if (exp_clk && exp_v == 1 && fmode == 2'b10) begin
                if (exp_h == 4)   check("ramp_px4", {vga_r, vga_g, vga_b}, 24'h010101);
                if (exp_h == 639) check("ramp_px639", {vga_r, vga_g, vga_b}, 24'h9F9F9F);
            end
            if (exp_clk && exp_v == 0 && fmode == 2'b11) begin
                if (exp_h == 32) check("check_px32", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
                if (exp_h == 64) check("check_px64", {vga_r, vga_g, vga_b}, 24'h000000);
            end
            if (exp_clk && exp_v == 1 && fmode == 2'b01) begin
                if (exp_h == 0)   check("grid_px0", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
                if (exp_h == 1)   check("grid_px1", {vga_r, vga_g, vga_b}, 24'h000000);
                if (exp_h == 639) check("grid_px639", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
            end
            if (exp_clk && exp_v == VA && exp_h == 0)
                check("blank_line_va", {23'd0, vga_blank_n}, 24'd0);
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_clk"}, {23'd0, vga_clk}, 24'd0);
        check({tag, "_hs"}, {23'd0, vga_hs}, 24'd1);
        check({tag, "_vs"}, {23'd0, vga_vs}, 24'd1);
        check({tag, "_blank"}, {23'd0, vga_blank_n}, 24'd0);
        check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 24'd0);
    endtask

    // Runs n cycles with random mid-frame key noise, then settles the mode for the next frame.
    task automatic run_cycles(input int n, input logic [1:0] next_mode, input bit settle);
        for (int c = 0; c < n; c++) begin
            if (c < n - 100 && $urandom_range(0, 499) == 0)
                key[3:1] = 3'($urandom);
            if (settle && c == n - 100)
                key[2:1] = next_mode;
            @(negedge clock_50);
        end
    endtask

    initial begin
        int n;
        bit found;
        key = 4'b0001;
        repeat (2) @(negedge clock_50);
        check_reset_state("reset");
        key = 4'b0000;
        run_cycles(FRAME_CYC, 2'b10, 1'b1);
        run_cycles(FRAME_CYC, 2'b11, 1'b1);
        run_cycles(2 * HT * 3, 2'b11, 1'b0);
        key = 4'b0011;
        @(negedge clock_50);
        check_reset_state("midreset");
        @(negedge clock_50);
        key = 4'b0010;
        n = 0;
        found = 1'b0;
        while (n < 20000 && !found) begin
            @(posedge clock_50);
            n++;
            @(negedge clock_50);
            if (!vga_vs) found = 1'b1;
        end
        check("vs_after_reset_cycles", 24'(n), 24'(2 * (VA + VF) * HT + 1));
        repeat (1000) @(negedge clock_50);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
